chip8_fetch: RTL
================

// Module: chip8_fetch
// PURPOSE
//   Instruction-fetch initiator for the CHIP-8 core; drives the read side of the
//   4 KiB byte memory (combinational read: data valid in the same cycle as addr).
//   Reads two consecutive bytes big-endian, assembles the 16-bit opcode and hands
//   it to decode over a valid/ready handshake. Owns the program counter; accepts
//   jump redirects from execute.
// PARAMETERS
//   RESET_PC   12'h200  PC value after reset (CHIP-8 program start)
// PORTS
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   reset, asynchronous, active-low
//   run           in   1   permit starting a new fetch
//   mem_addr      out  12  byte address to memory
//   mem_data      in   8   memory read data, combinational from mem_addr
//   op_valid      out  1   opcode/op_pc valid
//   op_ready      in   1   decode accepts opcode
//   opcode        out  16  {mem[op_pc], mem[op_pc+1]}
//   op_pc         out  12  address of opcode's high byte
//   pc_load       in   1   redirect PC (jump/call/return/skip)
//   pc_load_addr  in   12  redirect target
//   pc            out  12  current fetch PC
// BEHAVIOUR
//   Reset (async, rst_n=0): state=FETCH_HI, pc=RESET_PC, opcode=16'h0000,
//     op_pc=12'h000, op_valid=0, hi_byte=8'h00. Resets mid-operation discard all.
//   mem_addr (combinational): FETCH_HI -> pc; FETCH_LO -> pc+1; HOLD -> pc.
//   FETCH_HI: run=1 -> hi_byte<=mem_data, go FETCH_LO; run=0 -> stay, no change.
//   FETCH_LO: opcode<={hi_byte,mem_data}, op_pc<=pc, pc<=pc+2, op_valid<=1,
//     go HOLD. Completes regardless of run.
//   HOLD: opcode/op_pc stable while op_valid=1 and op_ready=0. op_ready=1 ->
//     op_valid<=0, go FETCH_HI. run ignored in HOLD.
//   pc_load=1 (any state, highest priority): pc<=pc_load_addr, op_valid<=0,
//     go FETCH_HI; in-flight partial fetch discarded. Combined with op_ready in
//     HOLD this is the normal jump: current opcode consumed, next fetch at target.
//   Latency: 2 cycles FETCH_HI entry -> op_valid=1; with op_ready held high and
//     run=1, one opcode per 3 cycles.
//   Arithmetic: all address math 12-bit modulo 4096. pc=12'hFFF: low byte read
//     from 12'h000, pc becomes 12'h001. pc=12'hFFE: pc becomes 12'h000.
//   Odd pc_load_addr accepted as-is (no alignment check).
//   op_valid never drops without op_ready or pc_load or reset.
// STRUCTURE
//   Shared package chip8_pkg: CHIP8_ADDR_W=12, CHIP8_MEM_BYTES=4096,
//     CHIP8_PROG_START=12'h200, CHIP8_OP_W=16, fetch state encoding
//     (FETCH_HI=2'd0, FETCH_LO=2'd1, HOLD=2'd2; 2'd3 illegal -> FETCH_HI).
//   Single module, no sub-module; PC register, hi_byte latch, opcode register
//   and 3-state FSM inline. Bench instantiates chip8_mem as the responder.
// TESTING
//   1 mem[200..203]=12 34 60 0A, run=1, op_ready=1 from reset -> op_valid 2
//     cycles after reset release: 0x1234/op_pc 0x200; 3 cycles later
//     0x600A/op_pc 0x202; pc=0x204.
//   2 Same image, op_ready=0 for 5 cycles in HOLD -> opcode=0x1234,
//     op_valid=1, mem_addr=pc=0x202 stable; op_ready=1 -> next op 0x600A.
//   3 In HOLD assert op_ready=1 and pc_load=1, pc_load_addr=0x300,
//     mem[300..301]=A2 F0 -> next opcode 0xA2F0, op_pc 0x300, pc 0x302.
//   4 pc_load_addr=0xFFF, mem[FFF]=AB, mem[000]=CD -> mem_addr 0xFFF then
//     0x000; opcode 0xABCD, op_pc 0xFFF, pc 0x001.
//   5 pc_load=1 (addr 0x208) during FETCH_LO of 0x200 -> no op_valid for
//     0x200; next opcode from 0x208/0x209.
//   6 run=0 after reset -> stays FETCH_HI, op_valid=0, pc 0x200; rst_n pulse
//     while in HOLD -> op_valid=0 immediately (async), pc=0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: address/opcode widths, program start address and
// the instruction-fetch state encoding.
package chip8_pkg;

  localparam int unsigned CHIP8_ADDR_W     = 12;
  localparam int unsigned CHIP8_MEM_BYTES  = 4096;
  localparam int unsigned CHIP8_OP_W       = 16;
  localparam logic [CHIP8_ADDR_W-1:0] CHIP8_PROG_START = 12'h200;

  // 2'd3 is unused; the fetch FSM recovers from it to FETCH_HI.
  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/chip8_mem.sv
// 4 KiB CHIP-8 byte memory: synchronous write port, combinational read port.
module chip8_mem
  import chip8_pkg::*;
(
  input  logic                    clk,
  input  logic                    we,
  input  logic [CHIP8_ADDR_W-1:0] waddr,
  input  logic [7:0]              wdata,
  input  logic [CHIP8_ADDR_W-1:0] raddr,
  output logic [7:0]              rdata
);

  logic [7:0] mem [CHIP8_MEM_BYTES];

  // Byte write on the rising edge.
  // NOTE: the array has no reset; clearing 4096 entries would prevent RAM
  // inference, and the contents are defined by whoever loads the program.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two consecutive bytes big-endian from the
// combinational byte memory, presents the opcode on a valid/ready handshake and
// owns the program counter, which execute may redirect at any time.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter logic [CHIP8_ADDR_W-1:0] RESET_PC = CHIP8_PROG_START
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  output logic [CHIP8_ADDR_W-1:0] mem_addr,
  input  logic [7:0]              mem_data,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [CHIP8_OP_W-1:0]   opcode,
  output logic [CHIP8_ADDR_W-1:0] op_pc,
  input  logic                    pc_load,
  input  logic [CHIP8_ADDR_W-1:0] pc_load_addr,
  output logic [CHIP8_ADDR_W-1:0] pc
);

  fetch_state_e state, next_state;
  logic [7:0]   hi_byte;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_HI;
    else        state <= next_state;
  end

  // Next-state and memory address; a redirect overrides everything.
  // NOTE: defaults are assigned first so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_state = FETCH_HI;
    mem_addr   = pc;
    unique case (state)
      FETCH_HI: next_state = run ? FETCH_LO : FETCH_HI;
      FETCH_LO: begin
        next_state = HOLD;
        mem_addr   = pc + 12'd1;  // wraps 0xFFF -> 0x000
      end
      HOLD:     next_state = op_ready ? FETCH_HI : HOLD;
      default:  next_state = FETCH_HI;
    endcase
    if (pc_load) next_state = FETCH_HI;
  end

  // PC, high-byte latch, opcode register and handshake flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      hi_byte  <= 8'h00;
      opcode   <= '0;
      op_pc    <= '0;
      op_valid <= 1'b0;
    end else if (pc_load) begin
      // A partial fetch is simply abandoned; hi_byte is rewritten next time.
      pc       <= pc_load_addr;
      op_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: if (run) hi_byte <= mem_data;
        FETCH_LO: begin
          opcode   <= {hi_byte, mem_data};
          op_pc    <= pc;
          pc       <= pc + 12'd2;
          op_valid <= 1'b1;
        end
        HOLD:     if (op_ready) op_valid <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule
